mix_columns_seq: RTL
====================

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning columns processed per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port IN_VALID, input, 1: the input state is valid.
REQ-005 SHALL have port IN_READY, output, 1: the block accepts input.
REQ-006 SHALL have port IN_MODE, input, 1: 0 = forward MixColumns, 1 = InvMixColumns.
REQ-007 SHALL have port IN_STATE, input, 128: column c in [127-32c -: 32], row 0 in the column's MSByte.
REQ-008 SHALL have port OUT_VALID, output, 1: the result is valid.
REQ-009 SHALL have port OUT_READY, input, 1: the downstream accepts the result.
REQ-010 SHALL have port OUT_STATE, output, 128: the result, same byte order as IN_STATE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE -> CALC on IN_VALID&&IN_READY; CALC -> DONE after the last column group; DONE -> IDLE on OUT_READY.
REQ-012 SHALL assert IN_READY only in IDLE.
- On acceptance, SHALL register IN_STATE and IN_MODE.
- Later changes on those inputs SHALL NOT affect the transaction.
REQ-013 In CALC, SHALL transform LANES columns per cycle, column 0 first, using a column counter that wraps at 4/LANES.
REQ-014 SHALL assert OUT_VALID exactly 4/LANES+1 cycles after the accept edge (LANES=4: 2 cycles).
REQ-015 Forward mode SHALL compute out_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), rows mod 4.
REQ-016 Inverse mode SHALL compute out_r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3).
REQ-017 All GF(2^8) products SHALL reduce by x^8+x^4+x^3+x+1 (xtime XOR 8'h1B when the MSB is set).
- Results SHALL be exactly 8 bits per byte.
REQ-018 In DONE, with OUT_READY low, OUT_VALID and OUT_STATE SHALL hold stable.
REQ-019 OUT_STATE SHALL be zero whenever OUT_VALID is low.
REQ-020 Back-to-back throughput: a new input MAY be accepted the cycle after the DONE->IDLE handshake, never earlier.

Reset
REQ-021 On RST, regardless of state:
- FSM SHALL go to IDLE.
- Column counter, state register and mode register SHALL clear to 0.
- OUT_VALID SHALL be 0, OUT_STATE SHALL be 0 and IN_READY SHALL be 1 after release.
REQ-022 RST asserted mid-CALC or mid-DONE SHALL discard the transaction with no partial output.

Configuration
REQ-023 Macro MIXCOL_INV_EN, defined: IN_MODE SHALL be honoured and inverse hardware SHALL be instantiated.
REQ-024 MIXCOL_INV_EN undefined: IN_MODE SHALL be ignored, forward mode only, and no 09/0B/0D/0E logic SHALL exist.

Structure
REQ-025 Shared package aes_pkg SHALL hold:
- the constant AES_POLY = 8'h1B;
- the typedefs aes_byte_t, aes_col_t (32 b) and aes_state_t (128 b);
- an xtime function;
- the FSM state enum.
REQ-026 SHALL use one combinational sub-module, mixcol_column (32-bit column plus mode in, 32-bit column out), instantiated LANES times.

Verification
REQ-027 Forward mode, LANES=1:
- column db 13 53 45 -> 8e 4d a1 bc;
- column f2 0a 22 5c -> 9f dc 58 9d;
- OUT_VALID exactly 5 cycles after accept.
REQ-028 Inverse mode, column 8e 4d a1 bc -> db 13 53 45.
- Forward then inverse of a random state SHALL return the original, for LANES=1, 2 and 4.
REQ-029 Fixed points in both modes:
- 01 01 01 01 -> 01 01 01 01;
- c6 c6 c6 c6 -> c6 c6 c6 c6;
- d4 d4 d4 d5 -> d5 d5 d7 d6 (forward).
REQ-030 Backpressure: OUT_READY held low 10 cycles -> OUT_STATE stable, IN_READY low, then IDLE one cycle after OUT_READY rises.
REQ-031 RST pulse during CALC -> OUT_VALID never rises, IN_READY is 1 after release, and the next transaction is correct.
REQ-032 MIXCOL_INV_EN undefined with IN_MODE=1 -> result equals the forward result (2d 26 31 4c -> 4d 7e bd f8).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns datapath: reduction polynomial,
// byte/column/state types, GF(2^8) doubling and the sequencer FSM encoding.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8); fold the carried-out bit back with the polynomial.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mixcol_column.sv
// One-column MixColumns transform, purely combinational.
// Build option MIXCOL_INV_EN adds the InvMixColumns path selected by mode;
// without it only the forward matrix exists and mode is ignored.
module mixcol_column
    import aes_pkg::*;
(
    input  aes_col_t col_in,
    input  logic     mode,
    output aes_col_t col_out
);

    aes_byte_t a  [4];
    aes_byte_t x2 [4];
    aes_byte_t fwd[4];

`ifdef MIXCOL_INV_EN
    aes_byte_t x4 [4];
    aes_byte_t x8 [4];
    aes_byte_t inv[4];
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;

        // Row 0 sits in the column's most significant byte.
        assign a[r]   = col_in[31-8*r -: 8];
        assign x2[r]  = xtime(a[r]);
        // 2*a_r ^ 3*a_r+1 ^ a_r+2 ^ a_r+3
        assign fwd[r] = x2[r] ^ x2[R1] ^ a[R1] ^ a[R2] ^ a[R3];

`ifdef MIXCOL_INV_EN
        assign x4[r]  = xtime(x2[r]);
        assign x8[r]  = xtime(x4[r]);
        // 0E = 8+4+2, 0B = 8+2+1, 0D = 8+4+1, 09 = 8+1
        assign inv[r] = (x8[r]  ^ x4[r]  ^ x2[r])
                      ^ (x8[R1] ^ x2[R1] ^ a[R1])
                      ^ (x8[R2] ^ x4[R2] ^ a[R2])
                      ^ (x8[R3] ^ a[R3]);
        assign col_out[31-8*r -: 8] = mode ? inv[r] : fwd[r];
`else
        assign col_out[31-8*r -: 8] = fwd[r];
`endif
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: accepts a 128-bit state, transforms LANES
// columns per cycle (column 0 first), then presents the result until taken.
// LANES must be 1, 2 or 4. Build option MIXCOL_INV_EN enables IN_MODE=1
// (InvMixColumns); otherwise IN_MODE is ignored and only forward is built.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic         IN_MODE,
    input  logic [127:0] IN_STATE,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT_STATE
);

    localparam int         GROUPS   = 4 / LANES;
    localparam logic [1:0] LAST_GRP = 2'(GROUPS - 1);

    mc_state_e state_q, state_d;
    logic [1:0] grp_q;
    logic       mode_q;
    logic       out_valid_q;

    // Ascending packed index: data_q[0] is column 0, i.e. bits 127:96.
    logic [0:3][31:0] data_q;
    logic [0:3][31:0] calc_d;

    logic [1:0]                  base;
    logic [LANES-1:0][1:0]       lane_idx;
    aes_col_t [LANES-1:0]        lane_in;
    aes_col_t [LANES-1:0]        lane_out;

`ifndef MIXCOL_INV_EN
    logic unused_in_mode;
    assign unused_in_mode = IN_MODE;
`endif

    // First column of the group being processed this cycle.
    assign base = 2'(grp_q * LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = base + 2'(l);
        assign lane_in[l]  = data_q[lane_idx[l]];

        mixcol_column u_col (
            .col_in  (lane_in[l]),
            .mode    (mode_q),
            .col_out (lane_out[l])
        );
    end

    // Column c is owned by lane c%LANES and rewritten during group c/LANES.
    for (genvar c = 0; c < 4; c++) begin : g_col
        localparam logic [1:0] GRP_C  = 2'(c / LANES);
        localparam int         LANE_C = c % LANES;
        assign calc_d[c] = (grp_q == GRP_C) ? lane_out[LANE_C] : data_q[c];
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; DONE only releases once the result is actually visible.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (IN_VALID)                  state_d = ST_CALC;
            ST_CALC: if (grp_q == LAST_GRP)         state_d = ST_DONE;
            ST_DONE: if (out_valid_q && OUT_READY)  state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; the result bus is forced to zero when nothing is offered.
    always_comb begin
        IN_READY  = (state_q == ST_IDLE);
        OUT_VALID = out_valid_q;
        OUT_STATE = out_valid_q ? data_q : '0;
    end

    // Datapath: capture on accept, rewrite one column group per CALC cycle,
    // and raise OUT_VALID from a flop one cycle after entering DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q      <= '0;
            mode_q      <= 1'b0;
            grp_q       <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && IN_VALID) begin
                data_q <= IN_STATE;
`ifdef MIXCOL_INV_EN
                mode_q <= IN_MODE;
`else
                mode_q <= 1'b0;
`endif
                grp_q  <= 2'd0;
            end
            if (state_q == ST_CALC) begin
                data_q <= calc_d;
                grp_q  <= (grp_q == LAST_GRP) ? 2'd0 : grp_q + 2'd1;
            end
            out_valid_q <= (state_q == ST_DONE) && !(out_valid_q && OUT_READY);
        end
    end

endmodule
